// File: rtl/rib_timer_if.sv
// rib_timer_if: RIB slave-port signals between the interconnect and the timer
interface rib_timer_if;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        we_i;
    logic [31:0] data_o;
    logic        int_sig_o;

    modport master (output addr_i, data_i, we_i, input data_o, int_sig_o);
    modport slave  (input addr_i, data_i, we_i, output data_o, int_sig_o);
endinterface

// File: rtl/rib_timer.sv
// rib_timer: RIB slave timer/compare peripheral with prescaler, one-shot/periodic mode and level interrupt
module rib_timer #(
    parameter int          PRESC_W   = 16,
    parameter logic [31:0] VALUE_RST = 32'hFFFF_FFFF
) (
    input logic       clk,
    input logic       rst,
    rib_timer_if.slave bus
);
    logic               en, ie, auto_rl, pend;
    logic [PRESC_W-1:0] presc, pre;
    logic [31:0]        value, count;
    logic [5:0]         off;
    logic               wr_ctrl, wr_presc, wr_value, wr_count;
    logic               tick, match;
    logic               unused_addr;

    assign off         = bus.addr_i[7:2];
    assign unused_addr = ^{bus.addr_i[31:8], bus.addr_i[1:0]};
    assign wr_ctrl     = bus.we_i && off == 6'd0;
    assign wr_presc    = bus.we_i && off == 6'd1;
    assign wr_value    = bus.we_i && off == 6'd2;
    assign wr_count    = bus.we_i && off == 6'd3;
    assign tick        = en && pre == presc;
    assign match       = tick && count == value && !wr_count;
    assign bus.int_sig_o = pend & ie;

    // Register read mux; unmapped offsets read as zero
    always_comb begin
        bus.data_o = off == 6'd0 ? {28'h0, pend, auto_rl, ie, en} :
                     off == 6'd1 ? 32'(presc) :
                     off == 6'd2 ? value :
                     off == 6'd3 ? count : 32'h0;
    end

    // Counting runs first; software writes later in the block override it, except a PEND set beats W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            auto_rl <= 1'b0;
            pend    <= 1'b0;
            presc   <= '0;
            pre     <= '0;
            value   <= VALUE_RST;
            count   <= '0;
        end else begin
            if (en) pre <= tick ? '0 : pre + PRESC_W'(1);
            if (tick) count <= count == value ? 32'h0 : count + 32'd1;
            if (match && !auto_rl) en <= 1'b0;
            pend <= match | (pend & ~(wr_ctrl & bus.data_i[3]));
            if (wr_ctrl) begin
                en      <= bus.data_i[0];
                ie      <= bus.data_i[1];
                auto_rl <= bus.data_i[2];
                if (!bus.data_i[0]) pre <= '0;
            end
            if (wr_presc) begin
                presc <= bus.data_i[PRESC_W-1:0];
                pre   <= '0;
            end
            if (wr_value) value <= bus.data_i;
            if (wr_count) begin
                count <= bus.data_i;
                pre   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rib_timer.sv
// tb_rib_timer: scoreboard bench for rib_timer register access, counting, collisions and reset
module tb_rib_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    rib_timer_if bus ();
    rib_timer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.addr_i = {24'h0, a};
        bus.data_i = d;
        bus.we_i   = 1'b1;
        @(negedge clk);
        bus.we_i   = 1'b0;
        bus.addr_i = 32'h0;
        bus.data_i = 32'h0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        bus.addr_i = {24'h0, a};
        #1;
        check(tag_q.pop_front(), bus.data_o, exp_q.pop_front());
        bus.addr_i = 32'h0;
    endtask

    task automatic irq(input string tag, input logic e);
        exp_q.push_back({31'h0, e});
        tag_q.push_back(tag);
        #1;
        check(tag_q.pop_front(), {31'h0, bus.int_sig_o}, exp_q.pop_front());
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.addr_i = 32'h0;
        bus.data_i = 32'h0;
        bus.we_i   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd("rst_ctrl", 8'h00, 32'h0);
        rd("rst_presc", 8'h04, 32'h0);
        rd("rst_value", 8'h08, 32'hFFFF_FFFF);
        rd("rst_count", 8'h0C, 32'h0);
        irq("rst_int", 1'b0);
        wr(8'h04, 32'h1234_5678);
        rd("presc_trunc", 8'h04, 32'h0000_5678);
        wr(8'h10, 32'd5);
        rd("unmapped", 8'h10, 32'h0);

        wr(8'h04, 32'd0);
        wr(8'h08, 32'd3);
        wr(8'h00, 32'h7);
        cyc(1); rd("per_e1", 8'h0C, 32'd1);
        cyc(1); rd("per_e2", 8'h0C, 32'd2);
        cyc(1); rd("per_e3", 8'h0C, 32'd3);
        irq("per_int_lo", 1'b0);
        cyc(1); rd("per_e4_cnt", 8'h0C, 32'd0);
        rd("per_e4_ctrl", 8'h00, 32'hF);
        irq("per_int_hi", 1'b1);
        cyc(3); rd("per_e7", 8'h0C, 32'd3);
        cyc(1); rd("per_e8_cnt", 8'h0C, 32'd0);
        rd("per_e8_en", 8'h00, 32'hF);
        wr(8'h00, 32'h8);
        rd("per_off", 8'h00, 32'h0);
        irq("per_int_clr", 1'b0);

        wr(8'h04, 32'd4);
        wr(8'h08, 32'd1);
        wr(8'h0C, 32'd0);
        wr(8'h00, 32'h3);
        cyc(4); rd("os_e4", 8'h0C, 32'd0);
        cyc(1); rd("os_e5", 8'h0C, 32'd1);
        cyc(4); rd("os_e9", 8'h00, 32'h3);
        cyc(1); rd("os_e10_ctrl", 8'h00, 32'hA);
        rd("os_e10_cnt", 8'h0C, 32'd0);
        irq("os_int", 1'b1);
        cyc(20); rd("os_hold", 8'h0C, 32'd0);

        wr(8'h00, 32'hF);
        rd("w1c_ctrl", 8'h00, 32'h7);
        irq("w1c_int", 1'b0);
        cyc(5); rd("w1c_w5", 8'h0C, 32'd1);
        cyc(4); rd("w1c_w9", 8'h00, 32'h7);
        wr(8'h00, 32'hF);
        rd("coll_pend", 8'h00, 32'hF);
        rd("coll_cnt", 8'h0C, 32'd0);
        irq("coll_int", 1'b1);

        wr(8'h00, 32'h8);
        wr(8'h08, 32'h1000);
        wr(8'h0C, 32'd0);
        wr(8'h00, 32'h1);
        cyc(9); rd("cw_s9", 8'h0C, 32'd1);
        wr(8'h0C, 32'h100);
        rd("cw_wins", 8'h0C, 32'h100);
        cyc(4); rd("cw_s14", 8'h0C, 32'h100);
        cyc(1); rd("cw_s15", 8'h0C, 32'h101);

        wr(8'h00, 32'h0);
        wr(8'h04, 32'd0);
        wr(8'h08, 32'd5);
        wr(8'h0C, 32'hFFFF_FFFE);
        wr(8'h00, 32'h7);
        cyc(1); rd("wr_e1", 8'h0C, 32'hFFFF_FFFF);
        cyc(1); rd("wr_e2", 8'h0C, 32'd0);
        rd("wr_nopend", 8'h00, 32'h7);
        cyc(5); rd("wr_e7", 8'h0C, 32'd5);
        cyc(1); rd("wr_e8_cnt", 8'h0C, 32'd0);
        rd("wr_e8_ctrl", 8'h00, 32'hF);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        rd("mr_ctrl", 8'h00, 32'h0);
        rd("mr_presc", 8'h04, 32'h0);
        rd("mr_value", 8'h08, 32'hFFFF_FFFF);
        rd("mr_count", 8'h0C, 32'h0);
        irq("mr_int", 1'b0);
        cyc(3); rd("idle_count", 8'h0C, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
